// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
//   Receives PS/2 keyboard frames from the raw pins, checks start/parity/stop
//   framing, tracks the E0/F0 prefixes and maps a small set of set-2 scan codes
//   to uppercase ASCII for the keyboard control stage.
//
// Ports
//   CLK_50M    in   system clock
//   RST_N      in   asynchronous active-low reset
//   PS2_CLK    in   raw keyboard clock (asynchronous)
//   PS2_DAT    in   raw keyboard data (asynchronous)
//   ps2_byte   out  ASCII of the most recent mapped make code
//   ps2_state  out  high while the key in ps2_byte is held
//   scan_code  out  data byte of the last good frame
//   scan_valid out  one-cycle pulse when scan_code updates
//   rx_err     out  one-cycle pulse on parity, stop-bit or timeout error
module ps2_keyboard_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] ps2_byte,
    output logic       ps2_state,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       rx_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [16:0] TO_LIM = TIMEOUT_CYCLES[16:0];

    state_t      state;
    logic        clk_s1, clk_s2, clk_d;
    logic        dat_s1, dat_s2;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        par_bit;
    logic [16:0] to_cnt;
    logic        brk_flag, ext_flag;

    logic        fall;
    logic        frame_ok;
    logic        key_hit;
    logic [7:0]  key_ascii;

    // Falling edge of the synchronized keyboard clock.
    assign fall = clk_d & ~clk_s2;

    always_comb begin
        // At the stop-bit edge dat_s2 holds the stop bit.
        frame_ok  = dat_s2 & (^{shift, par_bit});
        key_hit   = 1'b1;
        key_ascii = 8'h00;
        case (shift)
            8'h1C:   key_ascii = 8'h41;
            8'h23:   key_ascii = 8'h44;
            8'h1B:   key_ascii = 8'h53;
            8'h4D:   key_ascii = 8'h50;
            8'h2D:   key_ascii = 8'h52;
            8'h1D:   key_ascii = 8'h57;
            8'h29:   key_ascii = 8'h20;
            default: key_hit   = 1'b0;
        endcase
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            // Synchronizers reset to the idle-high line level so leaving
            // reset never fabricates a falling edge.
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            clk_d      <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            brk_flag   <= 1'b0;
            ext_flag   <= 1'b0;
            ps2_byte   <= '0;
            ps2_state  <= 1'b0;
            scan_code  <= '0;
            scan_valid <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            clk_s1     <= PS2_CLK;
            clk_s2     <= clk_s1;
            clk_d      <= clk_s2;
            dat_s1     <= PS2_DAT;
            dat_s2     <= dat_s1;
            scan_valid <= 1'b0;
            rx_err     <= 1'b0;

            if (fall)
                to_cnt <= '0;
            else if (to_cnt != '1)
                to_cnt <= to_cnt + 17'd1;

            if (fall) begin
                case (state)
                    S_IDLE: begin
                        if (!dat_s2) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_bit <= dat_s2;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (frame_ok) begin
                            scan_valid <= 1'b1;
                            scan_code  <= shift;
                            if (shift == 8'hF0) begin
                                brk_flag <= 1'b1;
                            end else if (shift == 8'hE0) begin
                                ext_flag <= 1'b1;
                            end else begin
                                if (!ext_flag && key_hit) begin
                                    if (brk_flag) begin
                                        if (key_ascii == ps2_byte)
                                            ps2_state <= 1'b0;
                                    end else begin
                                        ps2_byte  <= key_ascii;
                                        ps2_state <= 1'b1;
                                    end
                                end
                                brk_flag <= 1'b0;
                                ext_flag <= 1'b0;
                            end
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE && to_cnt >= TO_LIM) begin
                // A fall clears the counter, so timeout only fires between edges.
                state  <= S_IDLE;
                rx_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx
//   Directed bench for ps2_keyboard_rx. The PS/2 bit period is shortened to
//   40 system cycles and the timeout to 400 cycles to keep the run short.
module tb_ps2_keyboard_rx;

    localparam int unsigned TO_CYC = 400;
    localparam int unsigned HALF   = 20;

    logic       CLK_50M;
    logic       RST_N;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] ps2_byte;
    logic       ps2_state;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       rx_err;

    int checks = 0;
    int errors = 0;
    int sv_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int wide_cnt = 0;
    logic sv_prev = 1'b0;
    logic err_prev = 1'b0;

    ps2_keyboard_rx #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .CLK_50M   (CLK_50M),
        .RST_N     (RST_N),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .ps2_byte  (ps2_byte),
        .ps2_state (ps2_state),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .rx_err    (rx_err)
    );

    initial CLK_50M = 1'b0;
    always #10 CLK_50M = ~CLK_50M;

    // Pulse monitors, sampled away from the active edge.
    always @(negedge CLK_50M) begin
        if (scan_valid) sv_cnt++;
        if (rx_err) err_cnt++;
        if (scan_valid && rx_err) both_cnt++;
        if ((scan_valid && sv_prev) || (rx_err && err_prev)) wide_cnt++;
        sv_prev  = scan_valid;
        err_prev = rx_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge CLK_50M);
    endtask

    // Send the low n bits of 'bits' LSB first. For a full 11-bit frame, the
    // response pulse must appear within 5 cycles of the last falling edge.
    task automatic send_bits(input logic [10:0] bits, input int n);
        logic seen;
        int   waited;
        for (int i = 0; i < n; i++) begin
            PS2_DAT = bits[i];
            clks(HALF / 2);
            PS2_CLK = 1'b0;
            waited = 0;
            if (i == 10) begin
                seen = 1'b0;
                for (int k = 0; k < 5 && !seen; k++) begin
                    @(negedge CLK_50M);
                    waited++;
                    if (scan_valid || rx_err) seen = 1'b1;
                end
                chk("resp_latency", {31'd0, seen}, 32'd1);
            end
            clks(HALF - waited);
            PS2_CLK = 1'b1;
            clks(HALF / 2);
        end
        PS2_DAT = 1'b1;
    endtask

    task automatic frame(input logic [7:0] d, input logic par_ok, input logic stop);
        logic p;
        p = par_ok ? ~(^d) : (^d);
        send_bits({stop, p, d, 1'b0}, 11);
        clks(4);
    endtask

    task automatic good(input logic [7:0] d);
        frame(d, 1'b1, 1'b1);
    endtask

    task automatic outs(input string tag, input logic [7:0] b, input logic s);
        @(negedge CLK_50M);
        chk({tag, "_byte"}, {24'd0, ps2_byte}, {24'd0, b});
        chk({tag, "_state"}, {31'd0, ps2_state}, {31'd0, s});
    endtask

    int sv0;
    int er0;

    initial begin
        RST_N   = 1'b0;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        clks(5);
        @(negedge CLK_50M);
        chk("rst_byte", {24'd0, ps2_byte}, 32'h00);
        chk("rst_state", {31'd0, ps2_state}, 32'd0);
        chk("rst_scan", {24'd0, scan_code}, 32'h00);
        chk("rst_valid", {31'd0, scan_valid}, 32'd0);
        chk("rst_err", {31'd0, rx_err}, 32'd0);
        RST_N = 1'b1;
        clks(10);

        // Press / release A
        sv0 = sv_cnt;
        good(8'h1C);
        outs("make_a", 8'h41, 1'b1);
        chk("scan_1c", {24'd0, scan_code}, 32'h1C);
        good(8'hF0);
        outs("f0_a", 8'h41, 1'b1);
        good(8'h1C);
        outs("brk_a", 8'h41, 1'b0);
        chk("sv_press_rel", sv_cnt - sv0, 32'd3);

        // Parity error then good D
        sv0 = sv_cnt;
        er0 = err_cnt;
        frame(8'h23, 1'b0, 1'b1);
        chk("par_err", err_cnt - er0, 32'd1);
        chk("par_nosv", sv_cnt - sv0, 32'd0);
        outs("par_hold", 8'h41, 1'b0);
        good(8'h23);
        outs("make_d", 8'h44, 1'b1);

        // Stop-bit error
        er0 = err_cnt;
        frame(8'h1B, 1'b1, 1'b0);
        chk("stop_err", err_cnt - er0, 32'd1);
        outs("stop_hold", 8'h44, 1'b1);

        // Timeout after start bit plus 4 data bits of 0x1B
        er0 = err_cnt;
        send_bits(11'b000_1011_0, 5);
        clks(TO_CYC + 50);
        chk("timeout_err", err_cnt - er0, 32'd1);
        outs("timeout_hold", 8'h44, 1'b1);
        good(8'h1B);
        outs("make_s", 8'h53, 1'b1);

        // Overlapping keys
        good(8'h1C);
        outs("ovl_a", 8'h41, 1'b1);
        good(8'h23);
        outs("ovl_d", 8'h44, 1'b1);
        good(8'hF0);
        good(8'h1C);
        outs("ovl_brk_a", 8'h44, 1'b1);
        good(8'hF0);
        good(8'h23);
        outs("ovl_brk_d", 8'h44, 1'b0);

        // Extended and unmapped codes
        sv0 = sv_cnt;
        good(8'hE0);
        good(8'h1C);
        outs("ext_a", 8'h44, 1'b0);
        good(8'h15);
        outs("unmapped", 8'h44, 1'b0);
        chk("sv_ext", sv_cnt - sv0, 32'd3);
        good(8'h4D);
        outs("make_p", 8'h50, 1'b1);
        good(8'h4D);
        outs("typematic", 8'h50, 1'b1);
        good(8'hF0);
        good(8'h1B);
        outs("brk_other", 8'h50, 1'b1);
        good(8'h29);
        outs("make_space", 8'h20, 1'b1);

        // Reset mid-frame after 6 bits
        send_bits(11'b0_0010_1101_0, 6);
        RST_N = 1'b0;
        clks(3);
        @(negedge CLK_50M);
        chk("mrst_byte", {24'd0, ps2_byte}, 32'h00);
        chk("mrst_state", {31'd0, ps2_state}, 32'd0);
        chk("mrst_scan", {24'd0, scan_code}, 32'h00);
        RST_N = 1'b1;
        clks(10);
        good(8'h2D);
        outs("make_r", 8'h52, 1'b1);
        chk("scan_2d", {24'd0, scan_code}, 32'h2D);

        clks(5);
        chk("no_overlap", both_cnt, 32'd0);
        chk("pulse_width", wide_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #4000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

- Receives PS/2 keyboard frames on the raw `PS2_CLK` and `PS2_DAT` pins, checks framing and parity, and tracks make/break prefixes.
- Maps a fixed set of set-2 scan codes to uppercase ASCII.
- Drives `ps2_byte` and `ps2_state` straight into the keyboard control stage: `ps2_byte` carries the ASCII of the held key, and `ps2_state` is high for as long as that key is held.

## Interface
- `TIMEOUT_CYCLES`, default 100000: idle CLK_50M cycles between PS/2 clock falling edges (2 ms) after which a partial frame is discarded.
- `CLK_50M` in 1: system clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `PS2_CLK` in 1: raw keyboard clock, asynchronous to CLK_50M.
- `PS2_DAT` in 1: raw keyboard data, asynchronous to CLK_50M.
- `ps2_byte` out 8: ASCII of the most recent mapped make code.
- `ps2_state` out 1: high while the key in `ps2_byte` is held.
- `scan_code` out 8: raw data byte of the last good frame.
- `scan_valid` out 1: one-cycle pulse when `scan_code` updates.
- `rx_err` out 1: one-cycle pulse on a parity error, stop-bit error or timeout.

## Operation
- **Input sync and edge detect.** `PS2_CLK` and `PS2_DAT` each pass through a 2-FF synchronizer. A falling edge is the synchronized clock going 1 then 0 on consecutive cycles. `PS2_DAT` is sampled only on falling-edge cycles.
- **Frame FSM states:** IDLE → DATA → PARITY → STOP.
  - IDLE: an edge with data=0 (start bit) moves to DATA with the bit counter cleared. An edge with data=1 is ignored.
  - DATA: 8 edges shift the data in LSB first, then move to PARITY.
  - PARITY: one edge captures the parity bit, then move to STOP.
  - STOP: one edge captures the stop bit. The frame is good only if the 8 data bits plus the parity bit have odd parity and stop=1. A good frame pulses `scan_valid` and updates `scan_code`; a bad frame pulses `rx_err` and is discarded. Either way, return to IDLE.
- **Timeout.** An 17-bit counter clears on every falling edge and increments otherwise. In any state other than IDLE, reaching TIMEOUT_CYCLES pulses `rx_err` and returns to IDLE. The counter saturates rather than wrapping.
- **Prefix handling (good frames only).**
  - 0xF0 sets `brk_flag`. 0xE0 sets `ext_flag`. Neither changes the outputs.
  - Any other byte is a key code. Both flags clear after that code is processed.
  - A key code with `ext_flag` set is ignored.
- **Mapping (set-2 code → ASCII).**
  - 0x1C→"A", 0x23→"D", 0x1B→"S", 0x4D→"P", 0x2D→"R", 0x1D→"W", 0x29→0x20 (space).
  - Unmapped codes leave `ps2_byte` and `ps2_state` unchanged.
- **Make of a mapped key:** `ps2_byte` ← ASCII, `ps2_state` ← 1.
  - A typematic repeat of the same make produces no change on the outputs.
  - A make of a different key while one is held switches `ps2_byte` and keeps `ps2_state` at 1.
- **Break of a mapped key:** if its ASCII equals `ps2_byte`, `ps2_state` ← 0 and `ps2_byte` holds its value. A break of any other key is ignored.
- **Error frames** do not alter `brk_flag`, `ext_flag`, `ps2_byte` or `ps2_state`.

## Timing
- **Reset values:**
  - `ps2_byte` = 0x00, `ps2_state` = 0, `scan_code` = 0x00.
  - `scan_valid` = 0, `rx_err` = 0.
  - FSM in IDLE, both flags and all counters 0.
  - Reset mid-frame discards the partial frame immediately.
- **Edge latency:** pin falling edge → internal edge pulse within 3 CLK_50M cycles.
- **Output latency:** `scan_valid` / `rx_err` assert on the cycle after the edge pulse for the stop bit. `ps2_byte` / `ps2_state` update on that same cycle (registered decode).
  - Bench bound: within 5 cycles of the 11th pin falling edge.
- **Pulse width:** `scan_valid` and `rx_err` are exactly 1 cycle wide and never assert together.
- **Output stability:** `ps2_byte` and `ps2_state` are registered and change only on a decoded key event.
- **Input rates:** PS/2 clock 10–16.7 kHz, giving ≥3000 CLK_50M cycles per bit. No glitch filter beyond the synchronizer is required.
- **Scope:** host-to-device transmission is not supported; both pins are inputs only.

## Test plan
- **Press/release "A":** frames 0x1C, then 0xF0, 0x1C (correct parity) → after the first frame `ps2_byte`=0x41 and `ps2_state`=1; after the second 0x1C, `ps2_state`=0 and `ps2_byte` stays 0x41. `scan_valid` pulses 3 times.
- **Parity error:** frame 0x23 with even parity → `rx_err` pulses once, `scan_valid` stays 0, outputs unchanged. The following good frame 0x23 gives `ps2_byte`=0x44.
- **Timeout:** start bit plus 4 data bits, then idle for 100000 cycles → `rx_err` pulses once and the FSM is in IDLE. A following good 0x1B gives `ps2_byte`=0x53 and `ps2_state`=1.
- **Overlapping keys:** make 0x1C, make 0x23, break 0x1C → `ps2_byte`=0x44 and `ps2_state`=1 throughout. A subsequent break 0x23 drives `ps2_state`=0.
- **Extended and unmapped codes:** E0 1C, then 0x15 → no change on `ps2_byte` / `ps2_state`, `scan_valid` pulses for each frame, and `ext_flag` is cleared afterwards. A following 0x4D gives `ps2_byte`=0x50.
- **Reset mid-frame:** `RST_N` low after 6 bits → all outputs at reset values. The next complete frame 0x2D gives `ps2_byte`=0x52.
